// File: rtl/store_write_buffer_if.sv
// store_write_buffer_if: CPU store, fill arbitration and memory write bundle for store_write_buffer
// Ports: st_valid/st_addr/st_data/st_ready (store push), fill_req/fill_addr/fill_gnt/mem_busy
// (fill arbitration), mem_en/mem_wr/mem_addr/mem_data (drain write), count/empty/full (status).
// master = CPU/controller side, slave = the buffer.
interface store_write_buffer_if #(
    parameter int DEPTH = 4
);
    logic                   st_valid;
    logic [15:0]            st_addr;
    logic [15:0]            st_data;
    logic                   st_ready;
    logic                   fill_req;
    logic [15:0]            fill_addr;
    logic                   fill_gnt;
    logic                   mem_busy;
    logic                   mem_en;
    logic                   mem_wr;
    logic [15:0]            mem_addr;
    logic [15:0]            mem_data;
    logic [$clog2(DEPTH):0] count;
    logic                   empty;
    logic                   full;
    modport master (
        output st_valid, st_addr, st_data, fill_req, fill_addr, mem_busy,
        input  st_ready, fill_gnt, mem_en, mem_wr, mem_addr, mem_data, count, empty, full
    );
    modport slave (
        input  st_valid, st_addr, st_data, fill_req, fill_addr, mem_busy,
        output st_ready, fill_gnt, mem_en, mem_wr, mem_addr, mem_data, count, empty, full
    );
endinterface

// File: rtl/store_write_buffer.sv
// store_write_buffer: write-through store FIFO draining to memory, arbitrating with cache fills
// Ports: clk, rst_n (async active-low), bus (store_write_buffer_if.slave).
// Optional feature: define WB_COALESCE_EN to merge a store into the newest entry on address match.
module store_write_buffer #(
    parameter int DEPTH      = 4,
    parameter int BLOCK_BITS = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    store_write_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0]      addr_q [DEPTH];
    logic [15:0]      data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [AW-1:0]    head, tail;
    logic [AW:0]      cnt, cnt_nxt;
    logic             empty_q, full_q, conflict, hit, push, drain;

    // Block match ignores the byte-offset bits by shifting them out of the XOR.
    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            conflict |= valid_q[i] && (((addr_q[i] ^ bus.fill_addr) >> BLOCK_BITS) == 16'd0);
    end

    assign bus.fill_gnt = rst_n && bus.fill_req && !bus.mem_busy && !conflict;
    assign drain        = !empty_q && !bus.mem_busy && !bus.fill_gnt;

`ifdef WB_COALESCE_EN
    logic [AW-1:0] newest;
    assign newest = tail - 1'b1;
    // Merging into an entry that is leaving this cycle would lose the store.
    assign hit = bus.st_valid && !empty_q && addr_q[newest] == bus.st_addr && !(newest == head && drain);
`else
    assign hit = 1'b0;
`endif

    assign bus.st_ready = !full_q || hit;
    assign push         = bus.st_valid && !full_q && !hit;
    assign cnt_nxt      = cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, drain};

    assign bus.mem_en   = drain;
    assign bus.mem_wr   = drain;
    assign bus.mem_addr = drain ? addr_q[head] : 16'd0;
    assign bus.mem_data = drain ? data_q[head] : 16'd0;
    assign bus.count    = cnt;
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= bus.st_addr;
            data_q[tail] <= bus.st_data;
        end
`ifdef WB_COALESCE_EN
        if (hit)
            data_q[newest] <= bus.st_data;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (push) begin
                valid_q[tail] <= 1'b1;
                tail          <= tail + 1'b1;
            end
            if (drain) begin
                valid_q[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            cnt     <= cnt_nxt;
            empty_q <= cnt_nxt == '0;
            full_q  <= cnt_nxt == DEPTH[AW:0];
        end
    end
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: randomized and directed check of store_write_buffer against a queue model
module tb_store_write_buffer;
    localparam int DEPTH = 4;
    localparam int BB    = 4;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    ent_t q[$];
    logic [15:0] dut_log[$];
    int errors = 0;
    int checks = 0;

    store_write_buffer_if #(.DEPTH(DEPTH)) bus();

    store_write_buffer #(.DEPTH(DEPTH), .BLOCK_BITS(BB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check every output against the queue model, then advance the model.
    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] d,
                        input logic fr, input logic [15:0] fa, input logic mb);
        logic conf, gnt, drn, hit, rdy;
        @(negedge clk);
        bus.st_valid  = v;
        bus.st_addr   = a;
        bus.st_data   = d;
        bus.fill_req  = fr;
        bus.fill_addr = fa;
        bus.mem_busy  = mb;
        #1;
        conf = 1'b0;
        foreach (q[i]) if ((q[i].a >> BB) == (fa >> BB)) conf = 1'b1;
        gnt = fr && !mb && !conf;
        drn = q.size() != 0 && !mb && !gnt;
        hit = 1'b0;
`ifdef WB_COALESCE_EN
        hit = v && q.size() != 0 && q[$].a == a && !(q.size() == 1 && drn);
`endif
        rdy = q.size() < DEPTH || hit;
        check("st_ready", bus.st_ready, rdy);
        check("fill_gnt", bus.fill_gnt, gnt);
        check("mem_wr",   bus.mem_wr,   drn);
        check("mem_en",   bus.mem_en,   drn);
        check("mem_addr", bus.mem_addr, drn ? q[0].a : 16'd0);
        check("mem_data", bus.mem_data, drn ? q[0].d : 16'd0);
        check("count",    bus.count,    q.size());
        check("empty",    bus.empty,    q.size() == 0);
        check("full",     bus.full,     q.size() == DEPTH);
        if (bus.mem_wr) dut_log.push_back(bus.mem_addr);
        @(posedge clk);
        if (hit) q[$].d = d;
        else if (v && rdy) q.push_back('{a: a, d: d});
        if (drn) void'(q.pop_front());
    endtask

    task automatic idle(input int n, input logic mb);
        for (int i = 0; i < n; i++) step(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, mb);
    endtask

    initial begin
        bus.st_valid  = 1'b0;
        bus.st_addr   = 16'd0;
        bus.st_data   = 16'd0;
        bus.fill_req  = 1'b1;
        bus.fill_addr = 16'd0;
        bus.mem_busy  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_fill_gnt", bus.fill_gnt, 1'b0);
        check("rst_st_ready", bus.st_ready, 1'b1);
        check("rst_empty",    bus.empty,    1'b1);
        check("rst_full",     bus.full,     1'b0);
        check("rst_count",    bus.count,    0);
        check("rst_mem_wr",   bus.mem_wr,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // single store drains the next cycle
        step(1'b1, 16'h0010, 16'hAAAA, 1'b0, 16'd0, 1'b0);
        idle(2, 1'b0);

        // fill buffer under mem_busy, fifth push refused, then drain in order
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0200 + 16'(i * 2), 16'(16'h1000 + i), 1'b0, 16'd0, 1'b1);
        dut_log.delete();
        idle(5, 1'b0);
        check("burst_len", dut_log.size(), 4);
        for (int i = 0; i < 4 && i < dut_log.size(); i++) check("burst_order", dut_log[i], 16'h0200 + 16'(i * 2));

        // fill conflict, then non-conflicting fill
        step(1'b1, 16'h0024, 16'h5555, 1'b0, 16'd0, 1'b1);
        step(1'b0, 16'd0, 16'd0, 1'b1, 16'h0020, 1'b0);
        step(1'b0, 16'd0, 16'd0, 1'b1, 16'h0020, 1'b0);
        step(1'b1, 16'h0024, 16'h6666, 1'b0, 16'd0, 1'b1);
        step(1'b0, 16'd0, 16'd0, 1'b1, 16'h0100, 1'b0);
        idle(2, 1'b0);

        // async reset mid-stream discards everything
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0300 + 16'(i), 16'h7777, 1'b0, 16'd0, 1'b1);
        @(negedge clk);
        bus.st_valid  = 1'b0;
        bus.fill_req  = 1'b1;
        bus.fill_addr = 16'h0300;
        bus.mem_busy  = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_count",    bus.count,    0);
        check("mid_rst_mem_wr",   bus.mem_wr,   1'b0);
        check("mid_rst_st_ready", bus.st_ready, 1'b1);
        check("mid_rst_fill_gnt", bus.fill_gnt, 1'b0);
        q.delete();
        #2 rst_n = 1'b1;
        dut_log.delete();
        idle(3, 1'b0);
        check("post_rst_writes", dut_log.size(), 0);

        // coalesce candidate: same address twice under mem_busy
        step(1'b1, 16'h0040, 16'h1111, 1'b0, 16'd0, 1'b1);
        step(1'b1, 16'h0040, 16'h2222, 1'b0, 16'd0, 1'b1);
        idle(3, 1'b0);

        // wrap-around: interleaved push/drain
        dut_log.delete();
        for (int i = 0; i < 10; i++) step(1'b1, 16'h0400 + 16'(i * 4), 16'(i), 1'b0, 16'd0, 1'b0);
        idle(2, 1'b0);
        check("wrap_len", dut_log.size(), 10);
        for (int i = 0; i < 10 && i < dut_log.size(); i++) check("wrap_order", dut_log[i], 16'h0400 + 16'(i * 4));

        // randomized traffic
        for (int n = 0; n < 600; n++)
            step($urandom_range(0, 9) < 6,
                 16'(($urandom_range(0, 7) << 4) | $urandom_range(0, 15)),
                 16'($urandom),
                 $urandom_range(0, 9) < 3,
                 16'(($urandom_range(0, 7) << 4) | $urandom_range(0, 15)),
                 $urandom_range(0, 9) < 3);
        idle(8, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/store_write_buffer.md
# store_write_buffer

Write-through store buffer between the CPU store path and main memory, downstream of the data cache. It absorbs word stores so a store no longer stalls the pipeline for the memory write, and drains them to memory one per cycle when memory is idle. It also arbitrates memory ownership with the cache controller's miss-fill requests. A fill is held off while any buffered store targets the same cache block, so fills never return stale data.

## Interface
- DEPTH, 4, number of store entries; power of two, ≥2
- BLOCK_BITS, 4, byte-offset bits of a cache block; conflict compare uses addr[15:BLOCK_BITS]
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- st_valid  in  1  CPU store request this cycle
- st_addr  in  16  store address
- st_data  in  16  store data
- st_ready  out  1  store accepted this cycle when st_valid & st_ready
- fill_req  in  1  cache controller requests memory for a block fill
- fill_addr  in  16  miss address of the fill
- fill_gnt  out  1  fill may start this cycle
- mem_busy  in  1  controller fill sequence in progress
- mem_en  out  1  memory enable for a buffered write
- mem_wr  out  1  memory write strobe
- mem_addr  out  16  write address
- mem_data  out  16  write data
- count  out  $clog2(DEPTH)+1  valid entries
- empty  out  1  count==0
- full  out  1  count==DEPTH

## Operation
- Circular FIFO with head and tail pointers and an occupancy counter.
- Each entry holds addr[15:0] and data[15:0].
- Push: st_valid & st_ready writes the entry at tail; tail and count increment.
- st_ready = !full.
  - Not relaxed by a same-cycle drain.
  - With WB_COALESCE_EN, also asserted on a coalesce hit.
- conflict: some valid entry has addr[15:BLOCK_BITS] == fill_addr[15:BLOCK_BITS].
- fill_gnt = fill_req & !mem_busy & !conflict.
  - Fill has priority over draining when there is no conflict.
- drain_fire = !empty & !mem_busy & !fill_gnt.
  - mem_en = mem_wr = drain_fire.
  - mem_addr and mem_data carry the head entry when drain_fire, else 0.
  - On drain_fire, head advances and count decrements.
- Push and drain in the same cycle: count is unchanged and the pointers both advance.
- Pointers wrap modulo DEPTH.
- Conflict state: the buffer keeps draining, since !fill_gnt allows it. fill_gnt rises in the first cycle in which no matching entry remains.
- A push during mem_busy is accepted normally; the CPU is stalled by the controller during fills, so there are no ordering hazards.
- The buffer never reorders stores.

## Timing
- Reset (rst_n low, asynchronous):
  - All entries invalidated; head, tail and count = 0.
  - empty=1, full=0, st_ready=1.
  - mem_en, mem_wr, mem_addr, mem_data = 0.
  - fill_gnt forced 0 while rst_n is low.
- Reset mid-drain or mid-fill discards all buffered stores; there is no partial state.
- A pushed store is drainable the cycle after acceptance; there is no bypass.
- Minimum push-to-memory latency: 1 cycle.
- Drain throughput: 1 word per cycle; memory accepts a write in the enable cycle.
- fill_gnt, drain_fire and mem_* are combinational from registered state and the current fill_req/mem_busy/fill_addr.
- count, empty and full are registered.

## Configuration
- WB_COALESCE_EN defined:
  - A push whose st_addr equals the newest valid entry's addr overwrites that entry's data.
  - No allocation, count unchanged, st_ready=1 even when full.
  - Exception: no coalesce when the newest entry is the head and drain_fire is asserted that cycle; the push then follows the normal path.
- Undefined: every accepted push allocates a new entry.

## Test plan
- Reset, then push (0x0010,0xAAAA) with mem_busy=0, fill_req=0 → next cycle mem_wr=1, mem_addr=0x0010, mem_data=0xAAAA; empty=1 after.
- mem_busy=1, push 4 stores → full=1, st_ready=0; a 5th push is refused. Release mem_busy → 4 consecutive mem_wr cycles in push order; count 4→0.
- Buffer holds 0x0024, fill_req with fill_addr=0x0020 → fill_gnt=0 until the 0x0024 entry drains, then fill_gnt=1 the next cycle. fill_addr=0x0100 with the same buffer → immediate fill_gnt=1, no mem_wr that cycle.
- Push 3 entries, hold mem_busy=1, pulse rst_n low mid-stream → count=0, mem_wr=0, st_ready=1; no writes issue after release.
- WB_COALESCE_EN with mem_busy=1: push (0x0040,0x1111) then (0x0040,0x2222) → count=1. On release, a single mem_wr with data 0x2222.
- Wrap-around: 10 push/drain cycles interleaved with DEPTH=4 → addresses drained in exact push order, pointers wrap correctly.
